morse_symbol_assembler: RTL and testbench
=========================================

Name: morse_symbol_assembler

Overview:
- Sits directly downstream of the dot/dash decoder stage.
- Consumes its single-cycle dot/dash pulses and the raw key level b.
- Measures key-up (idle) time in Morse time units and packs symbols into a character code.
- On a letter gap, emits the character (raw code plus ASCII) with lg; on a word gap, emits wg.

Parameters:
- TIME_UNIT, 4_999_999: prescaler terminal count; one time unit = TIME_UNIT+1 clk cycles (50 ms at 100 MHz).
- LETTER_GAP, 3: idle units that terminate a letter.
- WORD_GAP, 7: idle units, counted from the last symbol, that terminate a word.
- MAX_SYM, 5: maximum symbols per character.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- b  in  1  raw key level, 1 = key down
- dot  in  1  single-cycle pulse: dot completed
- dash  in  1  single-cycle pulse: dash completed
- char_valid  out  1  single-cycle pulse: character complete
- sym_code  out  5  packed symbols, dot=0, dash=1, last symbol in bit 0
- sym_len  out  3  number of valid symbols in sym_code (1..5)
- ascii  out  8  decoded character
- char_err  out  1  qualifies char_valid: symbol overflow occurred
- lg  out  1  letter-gap pulse, coincident with char_valid
- wg  out  1  word-gap pulse

Behaviour:
- Reset: all outputs, shift register, length, prescaler, gap counter and error flag cleared; state IDLE.
- Symbol capture:
  - dot or dash pulse: code_sr <= {code_sr[3:0], dash}; len_cnt++.
  - dot and dash in the same cycle: treated as dash.
  - Pulse with len_cnt==MAX_SYM: symbol dropped, err_flag set, len_cnt unchanged.
- Prescaler:
  - Counts while b==0 and state != IDLE.
  - Cleared on b==1, on any dot/dash pulse, and on entry to IDLE.
  - unit_tick when count==TIME_UNIT; count then wraps to 0.
- gap_units:
  - 4-bit, incremented on unit_tick, saturates at 15.
  - Cleared on b==1 and on dot/dash pulses.
- FSM:
  - IDLE: no symbols held. dot/dash -> COLLECT. Ignores gaps; lg/wg never fire from IDLE.
  - COLLECT: dot/dash append. gap_units reaches LETTER_GAP -> registered outputs next cycle: char_valid=1, lg=1, sym_code/sym_len/ascii/char_err loaded; internal code/len/err cleared; -> WAIT_WORD.
  - WAIT_WORD: gap keeps counting, not cleared.
    - gap_units reaches WORD_GAP -> wg=1 for one cycle, -> IDLE.
    - b==1 -> IDLE (no wg).
    - dot/dash -> COLLECT with that symbol as first.
- Output registers:
  - sym_code, sym_len, ascii and char_err hold their values until the next char_valid.
  - char_valid, lg and wg are one-cycle pulses.
- Latency: 1 clk from the unit_tick that reaches the threshold to the char_valid/lg or wg pulse.
- Reset mid-operation: partial character discarded; no char_valid is emitted after release.

Optional Feature:
- MORSE_ASCII_EN defined:
  - Combinational table maps (sym_len, sym_code) to A-Z (8'h41-8'h5A) and 0-9 (8'h30-8'h39).
  - Unmapped codes and char_err=1 give 8'h3F ('?').
- Not defined: no table is built; ascii is tied to 8'h00; all other behaviour unchanged.

Test Plan:
- Setup for all scenarios: TIME_UNIT=3 (4 clk/unit), MORSE_ASCII_EN defined.
- dot, dash, then b=0 for 12 clk -> one-cycle char_valid=lg=1; sym_len=2, sym_code=5'b00001, ascii=8'h41, char_err=0.
- Continue b=0 to 28 clk after the last symbol -> one wg pulse; b=0 held another 40 clk -> no further lg/wg.
- Six dot pulses, then 3-unit gap -> char_valid with sym_len=5, sym_code=5'b00000, char_err=1, ascii=8'h3F.
- dot, b=0 for 8 clk, b=1, then dash and 3-unit gap -> no intermediate char; sym_len=2, sym_code=2'b01 (A).
- dot and dash asserted in the same cycle, then gap -> sym_len=1, sym_code=1 (T, 8'h54).
- Two dots, then reset_n low for 2 clk mid-gap -> all outputs 0; b=0 for 40 clk afterwards -> no char_valid, lg or wg.

Source files
------------

// File: rtl/morse_symbol_assembler.sv
// -----------------------------------------------------------------------------
// morse_symbol_assembler
//
// Sits behind the dot/dash decoder. Collects dot/dash pulses into a packed
// character code, times key-up gaps in Morse units and, on a letter gap,
// publishes the character. A longer gap counted from the last symbol
// produces a word-gap pulse.
//
// Optional feature: define MORSE_ASCII_EN to build the Morse-to-ASCII table
// (A-Z, 0-9, '?' for unmapped/overflowed codes). Without it ascii is 8'h00.
//
// Parameters:
//   TIME_UNIT  prescaler terminal count; one unit = TIME_UNIT+1 clk cycles
//   LETTER_GAP idle units that close a letter
//   WORD_GAP   idle units since the last symbol that close a word
//   MAX_SYM    maximum symbols held per character
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   b          raw key level, 1 = key down
//   dot, dash  single-cycle symbol pulses (both together count as a dash)
//   char_valid single-cycle pulse, character outputs updated
//   sym_code   packed symbols, dot=0 dash=1, last symbol in bit 0
//   sym_len    number of valid symbols in sym_code
//   ascii      decoded character
//   char_err   more than MAX_SYM symbols were keyed for this character
//   lg         letter-gap pulse, coincident with char_valid
//   wg         word-gap pulse
// -----------------------------------------------------------------------------
// state     | meaning
// ----------+-----------------------------------------------------------------
// IDLE      | no symbols held, gaps ignored, prescaler parked at zero
// COLLECT   | symbols being appended, waiting for a letter gap
// WAIT_WORD | character emitted, gap still counting toward a word gap
// -----------------------------------------------------------------------------
module morse_symbol_assembler #(
   parameter int unsigned TIME_UNIT  = 4_999_999,
   parameter int unsigned LETTER_GAP = 3,
   parameter int unsigned WORD_GAP   = 7,
   parameter int unsigned MAX_SYM    = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       b,
   input  logic       dot,
   input  logic       dash,
   output logic       char_valid,
   output logic [4:0] sym_code,
   output logic [2:0] sym_len,
   output logic [7:0] ascii,
   output logic       char_err,
   output logic       lg,
   output logic       wg
);

   localparam int PW = (TIME_UNIT < 1) ? 1 : $clog2(TIME_UNIT + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COLLECT   = 2'd1,
      WAIT_WORD = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   pre_cnt;
   logic [3:0]      gap_units;
   logic [3:0]      gap_next;
   logic [4:0]      code_sr;
   logic [2:0]      len_cnt;
   logic            err_flag;
   logic            pulse;
   logic            count_en;
   logic            unit_tick;
   logic            lg_hit;
   logic            wg_hit;
   logic            emit_char;
   logic            emit_wg;

   assign pulse     = dot | dash;
   // Symbol pulses and key-down both restart idle timing, so neither counts.
   assign count_en  = !b && !pulse && (state != IDLE);
   assign unit_tick = count_en && (pre_cnt == PW'(TIME_UNIT));
   assign gap_next  = (gap_units == 4'd15) ? 4'd15 : gap_units + 4'd1;
   // Thresholds are detected on the tick that reaches them so the registered
   // pulses appear one clock after that tick.
   assign lg_hit    = unit_tick && (gap_next == 4'(LETTER_GAP));
   assign wg_hit    = unit_tick && (gap_next == 4'(WORD_GAP));

   // ---------------------------------------------------------------- FSM ---
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pulse) state_nxt = COLLECT;
         end
         COLLECT: begin
            if (lg_hit) state_nxt = WAIT_WORD;
         end
         WAIT_WORD: begin
            if (pulse)       state_nxt = COLLECT;
            else if (b)      state_nxt = IDLE;
            else if (wg_hit) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      emit_char = 1'b0;
      emit_wg   = 1'b0;
      case (state)
         COLLECT:   emit_char = lg_hit;
         WAIT_WORD: emit_wg   = wg_hit;
         default: begin
            emit_char = 1'b0;
            emit_wg   = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------ gap timing ---
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
      end else if (pulse || b || (state_nxt == IDLE)) begin
         pre_cnt <= '0;
      end else if (count_en) begin
         pre_cnt <= unit_tick ? '0 : pre_cnt + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         gap_units <= 4'd0;
      end else if (pulse || b) begin
         gap_units <= 4'd0;
      end else if (unit_tick) begin
         gap_units <= gap_next;
      end
   end

   // ------------------------------------------------- symbol capture ---
   // A letter gap cannot coincide with a pulse (the pulse blocks the tick),
   // so clearing on emit never loses a symbol.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         code_sr  <= 5'd0;
         len_cnt  <= 3'd0;
         err_flag <= 1'b0;
      end else if (emit_char) begin
         code_sr  <= 5'd0;
         len_cnt  <= 3'd0;
         err_flag <= 1'b0;
      end else if (pulse) begin
         if (len_cnt == 3'(MAX_SYM)) begin
            err_flag <= 1'b1;
         end else begin
            code_sr <= {code_sr[3:0], dash};
            len_cnt <= len_cnt + 3'd1;
         end
      end
   end

   // ------------------------------------------------ output registers ---
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         char_valid <= 1'b0;
         lg         <= 1'b0;
         wg         <= 1'b0;
         sym_code   <= 5'd0;
         sym_len    <= 3'd0;
         char_err   <= 1'b0;
      end else begin
         char_valid <= emit_char;
         lg         <= emit_char;
         wg         <= emit_wg;
         if (emit_char) begin
            sym_code <= code_sr;
            sym_len  <= len_cnt;
            char_err <= err_flag;
         end
      end
   end

`ifdef MORSE_ASCII_EN
   // Code bits above the symbol count are masked so only the keyed symbols
   // take part in the lookup.
   function automatic logic [7:0] morse_to_ascii(input logic [2:0] len,
                                                 input logic [4:0] code,
                                                 input logic       err);
      logic [4:0] mcode;
      logic [7:0] c;
      mcode = code & ~(5'h1F << len);
      c     = 8'h3F;
      if (!err) begin
         case ({len, mcode})
            {3'd1, 5'b00000}: c = 8'h45; // E
            {3'd1, 5'b00001}: c = 8'h54; // T
            {3'd2, 5'b00000}: c = 8'h49; // I
            {3'd2, 5'b00001}: c = 8'h41; // A
            {3'd2, 5'b00010}: c = 8'h4E; // N
            {3'd2, 5'b00011}: c = 8'h4D; // M
            {3'd3, 5'b00000}: c = 8'h53; // S
            {3'd3, 5'b00001}: c = 8'h55; // U
            {3'd3, 5'b00010}: c = 8'h52; // R
            {3'd3, 5'b00011}: c = 8'h57; // W
            {3'd3, 5'b00100}: c = 8'h44; // D
            {3'd3, 5'b00101}: c = 8'h4B; // K
            {3'd3, 5'b00110}: c = 8'h47; // G
            {3'd3, 5'b00111}: c = 8'h4F; // O
            {3'd4, 5'b00000}: c = 8'h48; // H
            {3'd4, 5'b00001}: c = 8'h56; // V
            {3'd4, 5'b00010}: c = 8'h46; // F
            {3'd4, 5'b00100}: c = 8'h4C; // L
            {3'd4, 5'b00110}: c = 8'h50; // P
            {3'd4, 5'b00111}: c = 8'h4A; // J
            {3'd4, 5'b01000}: c = 8'h42; // B
            {3'd4, 5'b01001}: c = 8'h58; // X
            {3'd4, 5'b01010}: c = 8'h43; // C
            {3'd4, 5'b01011}: c = 8'h59; // Y
            {3'd4, 5'b01100}: c = 8'h5A; // Z
            {3'd4, 5'b01101}: c = 8'h51; // Q
            {3'd5, 5'b11111}: c = 8'h30; // 0
            {3'd5, 5'b01111}: c = 8'h31; // 1
            {3'd5, 5'b00111}: c = 8'h32; // 2
            {3'd5, 5'b00011}: c = 8'h33; // 3
            {3'd5, 5'b00001}: c = 8'h34; // 4
            {3'd5, 5'b00000}: c = 8'h35; // 5
            {3'd5, 5'b10000}: c = 8'h36; // 6
            {3'd5, 5'b11000}: c = 8'h37; // 7
            {3'd5, 5'b11100}: c = 8'h38; // 8
            {3'd5, 5'b11110}: c = 8'h39; // 9
            default:          c = 8'h3F;
         endcase
      end
      return c;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ascii <= 8'h00;
      end else if (emit_char) begin
         ascii <= morse_to_ascii(len_cnt, code_sr, err_flag);
      end
   end
`else
   assign ascii = 8'h00;
`endif

endmodule

// File: tb/tb_morse_symbol_assembler.sv
module tb_morse_symbol_assembler;

   localparam int TU   = 3;
   localparam int UNIT = TU + 1;
   localparam int LGAP = 3;
   localparam int WGAP = 7;
   localparam int MAXS = 5;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       b;
   logic       dot;
   logic       dash;
   logic       char_valid;
   logic [4:0] sym_code;
   logic [2:0] sym_len;
   logic [7:0] ascii;
   logic       char_err;
   logic       lg;
   logic       wg;

   morse_symbol_assembler #(
      .TIME_UNIT (TU),
      .LETTER_GAP(LGAP),
      .WORD_GAP  (WGAP),
      .MAX_SYM   (MAXS)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .b         (b),
      .dot       (dot),
      .dash      (dash),
      .char_valid(char_valid),
      .sym_code  (sym_code),
      .sym_len   (sym_len),
      .ascii     (ascii),
      .char_err  (char_err),
      .lg        (lg),
      .wg        (wg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cv_seen, lg_seen, wg_seen;
   int msyms[$];

   string morse_tab [36] = '{
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
      "..-", "...-", ".--", "-..-", "-.--", "--..",
      "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
      "---..", "----."
   };

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_ascii(input string pat, input bit err);
`ifdef MORSE_ASCII_EN
      if (err) return 8'h3F;
      for (int i = 0; i < 36; i++)
         if (morse_tab[i] == pat) return (i < 26) ? 8'(65 + i) : 8'(48 + i - 26);
      return 8'h3F;
`else
      if (err || pat.len() > 0) return 8'h00;
      return 8'h00;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (char_valid) cv_seen++;
      if (lg) lg_seen++;
      if (wg) wg_seen++;
   endtask

   task automatic clr_mon();
      cv_seen = 0;
      lg_seen = 0;
      wg_seen = 0;
   endtask

   task automatic start_char();
      clr_mon();
      msyms.delete();
   endtask

   // kind: 0 dot, 1 dash, 2 dot and dash together
   task automatic pulse(input int kind);
      b    = 1'b0;
      dot  = (kind != 1);
      dash = (kind != 0);
      msyms.push_back((kind != 0) ? 1 : 0);
      step();
      dot  = 1'b0;
      dash = 1'b0;
   endtask

   task automatic idle(input int n);
      b = 1'b0;
      repeat (n) step();
   endtask

   task automatic key(input int n);
      b = 1'b1;
      repeat (n) step();
      b = 1'b0;
   endtask

   // Called right after the last symbol pulse of a character.
   task automatic expect_char(input string tag);
      int         n;
      bit         err;
      int         len;
      logic [4:0] code;
      string      pat;
      n    = msyms.size();
      err  = (n > MAXS);
      len  = err ? MAXS : n;
      code = 5'd0;
      pat  = "";
      for (int i = 0; i < len; i++) begin
         code = 5'((code << 1) | 5'(msyms[i]));
         if (msyms[i] != 0) pat = {pat, "-"};
         else               pat = {pat, "."};
      end
      idle(LGAP * UNIT - 1);
      chk({tag, "_no_early_char"}, 32'(cv_seen + lg_seen), 0);
      idle(1);
      chk({tag, "_char_valid"}, 32'(char_valid), 1);
      chk({tag, "_lg"}, 32'(lg), 1);
      chk({tag, "_sym_len"}, 32'(sym_len), 32'(len));
      chk({tag, "_sym_code"}, 32'(sym_code), 32'(code));
      chk({tag, "_char_err"}, 32'(char_err), 32'(err));
      chk({tag, "_ascii"}, 32'(ascii), 32'(model_ascii(pat, err)));
      chk({tag, "_no_wg"}, 32'(wg_seen), 0);
   endtask

   initial begin
      reset_n = 1'b0;
      b       = 1'b0;
      dot     = 1'b0;
      dash    = 1'b0;
      clr_mon();
      step();
      step();
      chk("reset_outputs", {19'd0, char_valid, sym_code, sym_len, ascii, char_err, lg, wg}, 0);
      reset_n = 1'b1;
      step();

      // dot, dash -> A, then word gap, then silence
      start_char();
      pulse(0);
      pulse(1);
      expect_char("s1_A");
      clr_mon();
      idle(WGAP * UNIT - LGAP * UNIT - 1);
      chk("s1_wg_not_early", 32'(wg_seen + lg_seen + cv_seen), 0);
      idle(1);
      chk("s1_wg_pulse", 32'(wg), 1);
      idle(40);
      chk("s1_single_wg", 32'(wg_seen), 1);
      chk("s1_no_more_lg", 32'(lg_seen + cv_seen), 0);
      chk("s1_sym_len_held", 32'(sym_len), 2);

      // six dots -> overflow
      start_char();
      for (int i = 0; i < 6; i++) begin
         pulse(0);
         if (i < 5) idle(2);
      end
      expect_char("s3_overflow");
      key(2);

      // dot, short gap, key down, dash -> single A
      start_char();
      pulse(0);
      idle(8);
      key(1);
      pulse(1);
      expect_char("s4_A");
      key(2);

      // dot and dash together -> T
      start_char();
      pulse(2);
      expect_char("s5_T");
      key(2);

      // randomized characters with varied spacing and endings
      for (int c = 0; c < 24; c++) begin
         int n;
         int ending;
         start_char();
         n = $urandom_range(1, 6);
         for (int i = 0; i < n; i++) begin
            if (i > 0) begin
               idle($urandom_range(0, LGAP * UNIT - 1));
               if ($urandom_range(0, 1) == 1) begin
                  key($urandom_range(1, 4));
                  idle($urandom_range(0, LGAP * UNIT - 1));
               end
            end
            pulse($urandom_range(0, 2));
         end
         expect_char($sformatf("rnd%0d", c));
         ending = $urandom_range(0, 2);
         if (ending == 0) begin
            clr_mon();
            idle(WGAP * UNIT - LGAP * UNIT - 1);
            chk($sformatf("rnd%0d_wg_not_early", c), 32'(wg_seen), 0);
            idle(1);
            chk($sformatf("rnd%0d_wg", c), 32'(wg), 1);
         end else if (ending == 1) begin
            key(2);
         end else begin
            idle($urandom_range(0, 10));
         end
      end

      // reset mid-gap discards the partial character
      start_char();
      pulse(0);
      idle(1);
      pulse(0);
      idle(5);
      reset_n = 1'b0;
      step();
      step();
      chk("rst_outputs_zero", {19'd0, char_valid, sym_code, sym_len, ascii, char_err, lg, wg}, 0);
      reset_n = 1'b1;
      clr_mon();
      idle(40);
      chk("rst_no_events", 32'(cv_seen + lg_seen + wg_seen), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
